hashrate_meter: RTL and testbench

Measures the miner's hash rate and formats it for the 3-digit 7-segment display. It counts `hash_done` pulses over a fixed window of clock cycles and converts the count to BCD with a sequential shift-add-3 (double-dabble) engine. It then scales the result to three significant digits with a decimal point and unit code. It sits directly upstream of `segment_display`: `data` drives its 12-bit `data` input and `dp` drives its `dp` input.

---
 rtl/hashrate_meter.sv | 169 ++++++++++++++++
 tb/tb_hashrate_meter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hashrate_meter.sv
// Hash-rate meter: counts hash_done pulses per window, converts the count to BCD
// by double-dabble and formats three significant digits with decimal point and unit.
module hashrate_meter #(
   parameter int unsigned WINDOW = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        hash_done,
   output logic [11:0] data,
   output logic [2:0]  dp,
   output logic [1:0]  unit,
   output logic        sat,
   output logic        valid
);

   // state | meaning
   // IDLE  | waiting for the terminal cycle of the measurement window
   // CONV  | 32 shift-add-3 steps turning the snapshot into 10 BCD digits
   // FMT   | pick three significant digits, dp and unit; pulse valid
   typedef enum logic [1:0] {S_IDLE, S_CONV, S_FMT} state_t;

   localparam int unsigned    WCW   = $clog2(WINDOW);
   localparam logic [WCW-1:0] WLAST = WCW'(WINDOW - 1);

   state_t         state_q, state_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [31:0]    acc_q, acc_d;
   logic           wsat_q, wsat_d;
   logic           snap_sat_q, snap_sat_d;
   logic [31:0]    bin_q, bin_d;
   logic [39:0]    bcd_q, bcd_d;
   logic [4:0]     step_q, step_d;
   logic [11:0]    data_q, data_d;
   logic [2:0]     dp_q, dp_d;
   logic [1:0]     unit_q, unit_d;
   logic           sat_q, sat_d;
   logic           valid_q, valid_d;

   logic           terminal;
   logic           acc_full;
   logic [31:0]    acc_next;
   logic           wsat_next;
   logic [39:0]    adj;
   logic [71:0]    shf;
   logic [3:0]     msd;
   logic [3:0]     top;
   logic [3:0]     lo;
   logic [3:0]     g3;
   logic [1:0]     unit_f;

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      acc_d      = acc_q;
      wsat_d     = wsat_q;
      snap_sat_d = snap_sat_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      step_d     = step_q;
      data_d     = data_q;
      dp_d       = dp_q;
      unit_d     = unit_q;
      sat_d      = sat_q;
      valid_d    = 1'b0;

      terminal  = enable && (wcnt_q == WLAST);
      acc_full  = (acc_q == 32'hFFFF_FFFF);
      acc_next  = (hash_done && !acc_full) ? acc_q + 32'd1 : acc_q;
      wsat_next = wsat_q | (hash_done & acc_full);

      if (!enable || terminal) begin
         wcnt_d = '0;
         acc_d  = '0;
         wsat_d = 1'b0;
      end else begin
         wcnt_d = wcnt_q + 1'b1;
         acc_d  = acc_next;
         wsat_d = wsat_next;
      end

      adj = bcd_q;
      for (int i = 0; i < 10; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      shf = {adj, bin_q} << 1;

      // Highest nonzero digit decides the scale; a zero value reads as "000".
      msd = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) msd = 4'(i);
      end
      case (msd)
         4'd0, 4'd1, 4'd2: unit_f = 2'd0;
         4'd3, 4'd4, 4'd5: unit_f = 2'd1;
         4'd6, 4'd7, 4'd8: unit_f = 2'd2;
         default:          unit_f = 2'd3;
      endcase
      top = (msd < 4'd2) ? 4'd2 : msd;
      lo  = top - 4'd2;
      g3  = {2'b00, unit_f} * 4'd3;

      case (state_q)
         S_IDLE: begin
            if (terminal) begin
               bin_d      = acc_next;
               snap_sat_d = wsat_next;
               bcd_d      = '0;
               step_d     = '0;
               state_d    = S_CONV;
            end
         end
         S_CONV: begin
            bcd_d  = shf[71:32];
            bin_d  = shf[31:0];
            step_d = step_q + 5'd1;
            if (step_q == 5'd31) state_d = S_FMT;
         end
         S_FMT: begin
            data_d  = 12'(bcd_q >> {lo, 2'b00});
            dp_d    = (g3 > lo) ? (3'b001 << (g3 - lo)) : 3'b000;
            unit_d  = unit_f;
            sat_d   = snap_sat_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wcnt_q     <= '0;
         acc_q      <= '0;
         wsat_q     <= 1'b0;
         snap_sat_q <= 1'b0;
         bin_q      <= '0;
         bcd_q      <= '0;
         step_q     <= '0;
         data_q     <= '0;
         dp_q       <= '0;
         unit_q     <= '0;
         sat_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         acc_q      <= acc_d;
         wsat_q     <= wsat_d;
         snap_sat_q <= snap_sat_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         step_q     <= step_d;
         data_q     <= data_d;
         dp_q       <= dp_d;
         unit_q     <= unit_d;
         sat_q      <= sat_d;
         valid_q    <= valid_d;
      end
   end

   assign data  = data_q;
   assign dp    = dp_q;
   assign unit  = unit_q;
   assign sat   = sat_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_hashrate_meter.sv
// Scoreboard bench for hashrate_meter: a window/count model pushes expected
// display results; a monitor pops and compares them on every valid pulse.
module tb_hashrate_meter;
   localparam int W1 = 64;
   localparam int W2 = 2000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        hash_done = 1'b0;
   logic [11:0] data;
   logic [2:0]  dp;
   logic [1:0]  unit;
   logic        sat;
   logic        valid;

   logic        enable2 = 1'b0;
   logic        hash_done2 = 1'b1;
   logic [11:0] data2;
   logic [2:0]  dp2;
   logic [1:0]  unit2;
   logic        sat2;
   logic        valid2;

   hashrate_meter #(.WINDOW(W1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .hash_done(hash_done),
      .data(data), .dp(dp), .unit(unit), .sat(sat), .valid(valid));

   hashrate_meter #(.WINDOW(W2)) dut2 (
      .clk(clk), .rst(rst), .enable(enable2), .hash_done(hash_done2),
      .data(data2), .dp(dp2), .unit(unit2), .sat(sat2), .valid(valid2));

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] data;
      logic [2:0]  dp;
      logic [1:0]  unit;
      logic        sat;
      int          cyc;
   } exp_t;

   exp_t            sbq[$];
   exp_t            mdl_e, mon_e, chk_e;
   int              n_chk = 0;
   int              n_pass = 0;
   int              cyc = 0;
   int              m_cnt = 0;
   longint unsigned m_acc = 0;
   logic            m_sat = 1'b0;
   logic [31:0]     fval;

   task automatic chk(input string name, input longint act, input longint req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Display value for a window count, straight from the decimal digits.
   function automatic exp_t fmt(input longint unsigned v, input logic s);
      exp_t            e;
      int              d[10];
      int              m, g, top;
      longint unsigned x;
      x = v;
      for (int i = 0; i < 10; i++) begin
         d[i] = int'(x % 10);
         x = x / 10;
      end
      m = 0;
      for (int i = 0; i < 10; i++) if (d[i] != 0) m = i;
      g   = m / 3;
      top = (m > 2) ? m : 2;
      e.data = {4'(d[top]), 4'(d[top-1]), 4'(d[top-2])};
      e.dp   = (3*g > top-2) ? 3'(1 << (3*g - (top-2))) : 3'b000;
      e.unit = 2'(g);
      e.sat  = s;
      e.cyc  = 0;
      return e;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_cnt = 0; m_acc = 0; m_sat = 1'b0;
         sbq.delete();
      end else if (!enable) begin
         m_cnt = 0; m_acc = 0; m_sat = 1'b0;
      end else begin
         if (hash_done) begin
            if (m_acc == 64'hFFFF_FFFF) m_sat = 1'b1;
            else m_acc++;
         end
         if (m_cnt == W1-1) begin
            mdl_e = fmt(m_acc, m_sat);
            mdl_e.cyc = cyc + 33;
            sbq.push_back(mdl_e);
            m_cnt = 0; m_acc = 0; m_sat = 1'b0;
         end else begin
            m_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && valid) begin
         if (sbq.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            mon_e = sbq.pop_front();
            chk("data", data, mon_e.data);
            chk("dp", dp, mon_e.dp);
            chk("unit", unit, mon_e.unit);
            chk("sat", sat, mon_e.sat);
            chk("valid_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic wait_wcnt(input int v);
      for (int i = 0; i < 3*W1; i++) begin
         @(negedge clk);
         if (m_cnt == v) return;
      end
      chk("wait_wcnt_timeout", 0, 1);
   endtask

   task automatic wait_valid(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (valid) return;
      end
      chk(name, 0, 1);
   endtask

   task automatic wait_valid2(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (valid2) return;
      end
      chk(name, 0, 1);
   endtask

   task automatic rand_window(input int pct);
      for (int i = 0; i < W1; i++) begin
         @(negedge clk);
         hash_done = ($urandom_range(0, 99) < pct);
      end
   endtask

   task automatic force_acc(input logic [31:0] v);
      hash_done = 1'b0;
      wait_wcnt(5);
      fval = v;
      force dut.acc_q = fval;
      m_acc = longint'(v);
      @(negedge clk);
      release dut.acc_q;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_data"}, data, 0);
      chk({tag, "_dp"}, dp, 0);
      chk({tag, "_unit"}, unit, 0);
      chk({tag, "_sat"}, sat, 0);
      chk({tag, "_valid"}, valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int rel, a, b;
      longint unsigned sweep[5];
      sweep[0] = 999; sweep[1] = 1000; sweep[2] = 12345;
      sweep[3] = 100000; sweep[4] = 64'hFFFF_FFFF;

      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");

      // idle window: first update lands WINDOW+34 cycles after release
      rst = 1'b0; enable = 1'b1; rel = cyc;
      wait_valid("first_valid_timeout", W1 + 40);
      chk("first_valid_latency", cyc - rel + 1, W1 + 34);

      // only the terminal-cycle pulse counts, then an empty window
      wait_wcnt(W1-1);
      hash_done = 1'b1;
      @(negedge clk);
      hash_done = 1'b0;
      wait_valid("term_hash_timeout", W1 + 40);
      wait_valid("empty_timeout", W1 + 40);

      for (int w = 0; w < 6; w++) rand_window($urandom_range(5, 100));
      hash_done = 1'b0;

      foreach (sweep[k]) begin
         force_acc(32'(sweep[k]));
         wait_valid("sweep_timeout", 2*W1 + 40);
      end

      force_acc(32'hFFFF_FFFE);
      foreach (sweep[k]) if (k < 3) begin
         wait_wcnt(20 + 10*k);
         hash_done = 1'b1;
         @(negedge clk);
         hash_done = 1'b0;
      end
      wait_valid("sat_timeout", 2*W1 + 40);
      rand_window(30);
      hash_done = 1'b0;
      wait_valid("clean_timeout", 2*W1 + 40);

      // full window so outputs are nonzero, then reset the next conversion
      wait_wcnt(0);
      hash_done = 1'b1;
      wait_wcnt(W1-1);
      @(negedge clk);
      hash_done = 1'b0;
      wait_valid("full_timeout", W1 + 40);
      chk("full_data", data, 12'h064);
      wait_wcnt(W1-1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_zero_outputs("midconv_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0; rel = cyc;
      wait_valid("post_rst_timeout", W1 + 40);
      chk("post_rst_latency", cyc - rel + 1, W1 + 34);

      // enable dropped mid-window discards that window
      wait_wcnt(50);
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         hash_done = $urandom_range(0, 1) == 1;
      end
      @(negedge clk);
      enable = 1'b1; rel = cyc;
      wait_valid("reenable_timeout", W1 + 40);
      chk("reenable_latency", cyc - rel + 1, W1 + 34);
      rand_window(60);
      hash_done = 1'b0;
      wait_valid("last_timeout", 2*W1 + 40);

      // continuous hashing on the long-window instance
      enable = 1'b0;
      @(negedge clk);
      enable2 = 1'b1; rel = cyc;
      wait_valid2("cont_timeout", W2 + 40);
      a = cyc;
      chk("cont_latency", a - rel + 1, W2 + 34);
      chk_e = fmt(W2, 1'b0);
      chk("cont_data", data2, chk_e.data);
      chk("cont_dp", dp2, chk_e.dp);
      chk("cont_unit", unit2, chk_e.unit);
      chk("cont_sat", sat2, 0);
      wait_valid2("cont2_timeout", W2 + 40);
      b = cyc;
      chk("cont_spacing", b - a, W2);
      chk("cont2_data", data2, 12'h200);
      chk("cont2_dp", dp2, 3'b100);
      chk("cont2_unit", unit2, 1);
      enable2 = 1'b0;

      for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
